uart_alu_bridge: RTL and testbench

- Byte-level responder between the UART receiver/transmitter pair and an internal 8-bit ALU.
- Collects three bytes from the UART receiver in order: operand A, operand B, opcode.
- Computes the result and hands one result byte to the UART transmitter, then waits for transmit completion before accepting the next frame.
- Sits between the receiver's done/data outputs and the transmitter's start/data inputs; all logic runs in the system clock domain, not on baud ticks.

---
 rtl/uart_alu_bridge.sv | 136 +++++++++++++
 tb/tb_uart_alu_bridge.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_bridge.sv
// Byte-level bridge: collects A, B, opcode from a UART receiver, runs an 8-bit ALU op,
// and hands the result byte to the UART transmitter, waiting for tx completion.
module uart_alu_bridge #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 6
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_rx_done,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_tx_done,
  output logic                  o_tx_signal,
  output logic [DATA_WIDTH-1:0] o_tx_data_byte,
  output logic                  o_busy,
  output logic                  o_op_error,
  output logic                  o_drop
);

  typedef enum logic [2:0] {
    S_WAIT_A, S_WAIT_B, S_WAIT_OP, S_EXEC, S_SEND, S_WAIT_TX
  } state_t;

  localparam logic [OP_WIDTH-1:0]   OP_ADD = OP_WIDTH'('h20);
  localparam logic [OP_WIDTH-1:0]   OP_SUB = OP_WIDTH'('h22);
  localparam logic [OP_WIDTH-1:0]   OP_AND = OP_WIDTH'('h24);
  localparam logic [OP_WIDTH-1:0]   OP_OR  = OP_WIDTH'('h25);
  localparam logic [OP_WIDTH-1:0]   OP_XOR = OP_WIDTH'('h26);
  localparam logic [OP_WIDTH-1:0]   OP_NOR = OP_WIDTH'('h27);
  localparam logic [OP_WIDTH-1:0]   OP_SRA = OP_WIDTH'('h03);
  localparam logic [OP_WIDTH-1:0]   OP_SRL = OP_WIDTH'('h02);
  localparam logic [DATA_WIDTH-1:0] SH_LIM = DATA_WIDTH'(DATA_WIDTH);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic                  tx_signal_q, tx_signal_d;
  logic                  busy_q, busy_d;
  logic                  op_err_q, op_err_d;
  logic                  drop_q, drop_d;
  logic                  rx_q, tx_q;
  logic                  rx_edge, tx_edge, in_busy;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_bad;

  assign rx_edge = i_rx_done & ~rx_q;
  assign tx_edge = i_tx_done & ~tx_q;
  assign in_busy = (state_q == S_EXEC) || (state_q == S_SEND) || (state_q == S_WAIT_TX);

  always_comb begin
    alu_res = '0;
    alu_bad = 1'b0;
    case (op_q)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_NOR:  alu_res = ~(a_q | b_q);
      // Shift amounts beyond the width saturate explicitly rather than relying on >>> semantics.
      OP_SRA:  alu_res = (b_q >= SH_LIM) ? {DATA_WIDTH{a_q[DATA_WIDTH-1]}}
                                         : $unsigned($signed(a_q) >>> b_q);
      OP_SRL:  alu_res = (b_q >= SH_LIM) ? '0 : (a_q >> b_q);
      default: alu_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    result_d    = result_q;
    op_err_d    = op_err_q;
    tx_signal_d = 1'b0;
    drop_d      = drop_q | (rx_edge & in_busy);
    unique case (state_q)
      S_WAIT_A: if (rx_edge) begin
        a_d      = i_rx_data;
        op_err_d = 1'b0;
        state_d  = S_WAIT_B;
      end
      S_WAIT_B: if (rx_edge) begin
        b_d     = i_rx_data;
        state_d = S_WAIT_OP;
      end
      S_WAIT_OP: if (rx_edge) begin
        op_d    = i_rx_data[OP_WIDTH-1:0];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        result_d    = alu_res;
        op_err_d    = alu_bad;
        tx_signal_d = 1'b1;
        state_d     = S_SEND;
      end
      S_SEND:    state_d = S_WAIT_TX;
      S_WAIT_TX: if (tx_edge) state_d = S_WAIT_A;
      default:   state_d = S_WAIT_A;
    endcase
    busy_d = (state_d == S_EXEC) || (state_d == S_SEND) || (state_d == S_WAIT_TX);
  end

  always_ff @(posedge i_clock) begin
    // Edge-detect history tracks inputs through reset so a level held across release is not a new byte.
    rx_q <= i_rx_done;
    tx_q <= i_tx_done;
    if (i_reset) begin
      state_q     <= S_WAIT_A;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      result_q    <= '0;
      tx_signal_q <= 1'b0;
      busy_q      <= 1'b0;
      op_err_q    <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      result_q    <= result_d;
      tx_signal_q <= tx_signal_d;
      busy_q      <= busy_d;
      op_err_q    <= op_err_d;
      drop_q      <= drop_d;
    end
  end

  assign o_tx_signal    = tx_signal_q;
  assign o_tx_data_byte = result_q;
  assign o_busy         = busy_q;
  assign o_op_error     = op_err_q;
  assign o_drop         = drop_q;

endmodule

// File: tb/tb_uart_alu_bridge.sv
// Self-checking bench for uart_alu_bridge: vector table, corner-case sequences,
// and random frames checked against an arithmetic reference model.
module tb_uart_alu_bridge;
  logic       i_clock = 1'b0;
  logic       i_reset;
  logic       i_rx_done;
  logic [7:0] i_rx_data;
  logic       i_tx_done;
  logic       o_tx_signal;
  logic [7:0] o_tx_data_byte;
  logic       o_busy;
  logic       o_op_error;
  logic       o_drop;

  int pass_cnt = 0;
  int total_cnt = 0;

  uart_alu_bridge #(.DATA_WIDTH(8), .OP_WIDTH(6)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_rx_done(i_rx_done), .i_rx_data(i_rx_data),
    .i_tx_done(i_tx_done), .o_tx_signal(o_tx_signal), .o_tx_data_byte(o_tx_data_byte),
    .o_busy(o_busy), .o_op_error(o_op_error), .o_drop(o_drop)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] opb;
    logic [7:0] exp;
    bit         err;
  } vec_t;

  task automatic chk(input string name, input int got, input int exp);
    total_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  // Reference ALU from plain integer arithmetic; bit 8 flags an unsupported opcode.
  function automatic int ref_alu(input int a, input int b, input int op);
    int sa, d, q;
    case (op)
      'h20: return (a + b) % 256;
      'h22: return (a - b + 256) % 256;
      'h24: return a & b;
      'h25: return a | b;
      'h26: return a ^ b;
      'h27: return 255 - (a | b);
      'h02: return (b >= 8) ? 0 : a / (1 << b);
      'h03: begin
        sa = (a >= 128) ? a - 256 : a;
        if (b >= 8) return (sa < 0) ? 255 : 0;
        d = 1 << b;
        q = (sa >= 0) ? sa / d : -((-sa + d - 1) / d);
        return (q + 256) % 256;
      end
      default: return 256;
    endcase
  endfunction

  task automatic send_byte(input logic [7:0] d, input int hold);
    i_rx_data = d;
    i_rx_done = 1'b1;
    repeat (hold) tick();
    i_rx_done = 1'b0;
    tick();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_tx_signal"}, int'(o_tx_signal), 0);
    chk({tag, "_tx_data"}, int'(o_tx_data_byte), 0);
    chk({tag, "_busy"}, int'(o_busy), 0);
    chk({tag, "_op_error"}, int'(o_op_error), 0);
    chk({tag, "_drop"}, int'(o_drop), 0);
  endtask

  // mode 0: plain; 1: extra byte during WAIT_TX; 2: rx edge coincident with tx edge
  task automatic do_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                          input logic [7:0] exp, input bit experr, input int hold, input int mode);
    int strobes = 0;
    int last = (hold > 3) ? hold : 3;
    send_byte(a, hold);
    chk("err_clr_on_a", int'(o_op_error), 0);
    send_byte(b, hold);
    i_rx_data = opb;
    i_rx_done = 1'b1;
    for (int c = 1; c <= last; c++) begin
      tick();
      if (o_tx_signal) strobes++;
      if (c == 1) begin
        chk("exec_busy", int'(o_busy), 1);
        chk("exec_no_strobe", int'(o_tx_signal), 0);
      end
      if (c == 2) begin
        chk("strobe_at_n2", int'(o_tx_signal), 1);
        chk("result", int'(o_tx_data_byte), int'(exp));
        chk("op_error", int'(o_op_error), int'(experr));
      end
      if (c == hold) i_rx_done = 1'b0;
    end
    chk("one_strobe", strobes, 1);
    if (mode == 1) begin
      send_byte(8'h99, 1);
      chk("drop_set", int'(o_drop), 1);
      chk("drop_still_busy", int'(o_busy), 1);
      chk("drop_data_held", int'(o_tx_data_byte), int'(exp));
    end
    chk("wait_tx_busy", int'(o_busy), 1);
    if (mode == 2) begin
      i_rx_data = 8'h77;
      i_rx_done = 1'b1;
    end
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    i_rx_done = 1'b0;
    chk("busy_fall", int'(o_busy), 0);
    if (mode == 2) chk("drop_on_coincident", int'(o_drop), 1);
    tick();
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    repeat (3) tick();
    i_reset = 1'b0;
    tick();
  endtask

  vec_t vecs[12];
  logic [7:0] ops[8];

  initial begin
    i_reset = 1'b1;
    i_rx_done = 1'b0;
    i_rx_data = 8'h00;
    i_tx_done = 1'b0;
    vecs[0]  = '{8'h05, 8'h03, 8'h20, 8'h08, 1'b0};
    vecs[1]  = '{8'h03, 8'h05, 8'h22, 8'hFE, 1'b0};
    vecs[2]  = '{8'h80, 8'h02, 8'h03, 8'hE0, 1'b0};
    vecs[3]  = '{8'h80, 8'h02, 8'h02, 8'h20, 1'b0};
    vecs[4]  = '{8'h80, 8'h09, 8'h03, 8'hFF, 1'b0};
    vecs[5]  = '{8'h12, 8'h34, 8'h3F, 8'h00, 1'b1};
    vecs[6]  = '{8'hF0, 8'h3C, 8'h24, 8'h30, 1'b0};
    vecs[7]  = '{8'hF0, 8'h3C, 8'h26, 8'hCC, 1'b0};
    vecs[8]  = '{8'hF0, 8'h0F, 8'h27, 8'h00, 1'b0};
    vecs[9]  = '{8'hFF, 8'h08, 8'h02, 8'h00, 1'b0};
    vecs[10] = '{8'h7F, 8'h0A, 8'h03, 8'h00, 1'b0};
    vecs[11] = '{8'hC5, 8'hE5, 8'hA0, 8'hAA, 1'b0};
    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};

    repeat (3) tick();
    i_reset = 1'b0;
    tick();
    check_reset_vals("reset");

    foreach (vecs[i]) do_frame(vecs[i].a, vecs[i].b, vecs[i].opb, vecs[i].exp, vecs[i].err, 1, 0);

    // Level-held rx_done: each byte counts once.
    do_frame(8'hF0, 8'h0F, 8'h25, 8'hFF, 1'b0, 5, 0);

    // Coincident rx/tx edges in WAIT_TX: byte dropped, next frame aligned.
    do_frame(8'h10, 8'h20, 8'h20, 8'h30, 1'b0, 1, 2);
    do_frame(8'h09, 8'h04, 8'h22, 8'h05, 1'b0, 1, 0);

    do_reset();
    chk("drop_cleared_by_reset", int'(o_drop), 0);
    do_frame(8'h40, 8'h01, 8'h20, 8'h41, 1'b0, 1, 1);
    do_frame(8'h0C, 8'h0A, 8'h26, 8'h06, 1'b0, 2, 0);

    for (int n = 0; n < 40; n++) begin
      logic [7:0] ra, rb, rop;
      int r;
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 10)) : 8'($urandom_range(0, 255));
      rop = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 63)) : ops[$urandom_range(0, 7)];
      r = ref_alu(int'(ra), int'(rb), int'(rop));
      rop = rop | 8'($urandom_range(0, 3) << 6);
      do_frame(ra, rb, rop, (r > 255) ? 8'h00 : 8'(r), r > 255, $urandom_range(1, 3), 0);
    end

    // Reset in WAIT_B with rx_done high: no capture at release.
    send_byte(8'h55, 1);
    i_rx_data = 8'h66;
    i_rx_done = 1'b1;
    i_reset = 1'b1;
    repeat (2) tick();
    check_reset_vals("mid_reset");
    i_reset = 1'b0;
    repeat (3) tick();
    i_rx_done = 1'b0;
    tick();
    chk("post_reset_busy", int'(o_busy), 0);
    do_frame(8'h01, 8'h01, 8'h20, 8'h02, 1'b0, 1, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
